// File: rtl/pipe_pkg.sv
// Shared definitions for the 5-stage pipeline hazard control slice.
package pipe_pkg;

    localparam int REG_AW = 3;

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_LDSTALL = 2'd1;
    localparam logic [1:0] ST_MEMWAIT = 2'd2;

    localparam int ZERO_REG_IDX = 0;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear taking priority over increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller: load-use bubbles, EX branch flush, data-memory wait with timeout,
// plus saturating stall and branch-flush counters.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int REG_AW       = pipe_pkg::REG_AW,
    parameter int LOAD_BUBBLES = 1,
    parameter int MEM_TIMEOUT  = 255,
    parameter int CNT_W        = 16,
    parameter int ZERO_REG_HW  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_is_load,
    input  logic              ex_br_taken,
    input  logic              mem_req,
    input  logic              mem_ack,
    input  logic              cnt_clr,
    output logic              pc_freeze,
    output logic              ifid_freeze,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic              exmem_freeze,
    output logic              mem_err,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    logic [1:0] state, state_nxt;
    logic [2:0] bub, bub_nxt;
    logic [7:0] to_cnt, to_nxt;
    logic       lu, mw, rd_zero;

    assign rd_zero = (ZERO_REG_HW != 0) && (ex_rd == REG_AW'(ZERO_REG_IDX));
    assign lu = ex_is_load && !rd_zero &&
                ((id_use_rs1 && (ex_rd == id_rs1)) || (id_use_rs2 && (ex_rd == id_rs2)));
    assign mw = mem_req && !mem_ack;

    // Without a pending wait every state falls through to RUN evaluation; LDSTALL only
    // differs by forcing the stall regardless of the current lu condition.
    always_comb begin
        pc_freeze    = 1'b0;
        ifid_freeze  = 1'b0;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        exmem_freeze = 1'b0;
        mem_err      = 1'b0;
        state_nxt    = ST_RUN;
        bub_nxt      = '0;
        to_nxt       = '0;
        if (mw) begin
            if ((state == ST_MEMWAIT) && (to_cnt == 8'(MEM_TIMEOUT))) begin
                mem_err = 1'b1;
            end else begin
                pc_freeze    = 1'b1;
                ifid_freeze  = 1'b1;
                exmem_freeze = 1'b1;
                state_nxt    = ST_MEMWAIT;
                to_nxt       = (state == ST_MEMWAIT) ? (to_cnt + 8'd1) : 8'd1;
            end
        end else if (ex_br_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if ((state == ST_LDSTALL) || lu) begin
            pc_freeze   = 1'b1;
            ifid_freeze = 1'b1;
            idex_flush  = 1'b1;
            if (state == ST_LDSTALL) begin
                if (bub > 3'd1) begin
                    bub_nxt   = bub - 3'd1;
                    state_nxt = ST_LDSTALL;
                end
            end else if (LOAD_BUBBLES > 1) begin
                bub_nxt   = 3'(LOAD_BUBBLES - 1);
                state_nxt = ST_LDSTALL;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_RUN;
            bub    <= '0;
            to_cnt <= '0;
        end else begin
            state  <= state_nxt;
            bub    <= bub_nxt;
            to_cnt <= to_nxt;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (pc_freeze),
        .clr (cnt_clr),
        .cnt (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (ifid_flush),
        .clr (cnt_clr),
        .cnt (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench: two controller instances (1 and 3 load bubbles) checked against a cycle-level reference model.
module tb_pipe_hazard_ctrl;

    localparam int MT   = 8;
    localparam int CW_A = 4;
    localparam int CW_B = 16;

    logic       clk = 1'b0;
    logic       rst, id_use_rs1, id_use_rs2, ex_is_load, ex_br_taken, mem_req, mem_ack, cnt_clr;
    logic [2:0] id_rs1, id_rs2, ex_rd;

    logic            a_pcf, a_iff, a_ifl, a_idf, a_exf, a_err;
    logic            b_pcf, b_iff, b_ifl, b_idf, b_exf, b_err;
    logic [CW_A-1:0] a_stall, a_flush;
    logic [CW_B-1:0] b_stall, b_flush;

    int passed = 0;
    int total  = 0;

    // Reference model: remaining stall cycles, cycles spent waiting, counters.
    int m_bub[2], m_wait[2], m_stall[2], m_flush[2];
    int n_bub[2], n_wait[2], n_stall[2], n_flush[2];
    int m_lb[2]  = '{1, 3};
    int m_max[2] = '{(1 << CW_A) - 1, (1 << CW_B) - 1};
    bit e_pcf[2], e_iff[2], e_ifl[2], e_idf[2], e_exf[2], e_err[2];

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.LOAD_BUBBLES(1), .MEM_TIMEOUT(MT), .CNT_W(CW_A), .ZERO_REG_HW(1)) dut_a (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
        .id_use_rs2(id_use_rs2), .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_br_taken(ex_br_taken),
        .mem_req(mem_req), .mem_ack(mem_ack), .cnt_clr(cnt_clr), .pc_freeze(a_pcf),
        .ifid_freeze(a_iff), .ifid_flush(a_ifl), .idex_flush(a_idf), .exmem_freeze(a_exf),
        .mem_err(a_err), .stall_cnt(a_stall), .flush_cnt(a_flush));

    pipe_hazard_ctrl #(.LOAD_BUBBLES(3), .MEM_TIMEOUT(MT), .CNT_W(CW_B), .ZERO_REG_HW(1)) dut_b (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
        .id_use_rs2(id_use_rs2), .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_br_taken(ex_br_taken),
        .mem_req(mem_req), .mem_ack(mem_ack), .cnt_clr(cnt_clr), .pc_freeze(b_pcf),
        .ifid_freeze(b_iff), .ifid_flush(b_ifl), .idex_flush(b_idf), .exmem_freeze(b_exf),
        .mem_err(b_err), .stall_cnt(b_stall), .flush_cnt(b_flush));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic model_eval(input int i);
        bit mw, lu;
        mw = mem_req && !mem_ack;
        lu = ex_is_load && (ex_rd != 0) &&
             ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
        {e_pcf[i], e_iff[i], e_ifl[i], e_idf[i], e_exf[i], e_err[i]} = '0;
        n_bub[i]  = 0;
        n_wait[i] = 0;
        if (mw && m_wait[i] == MT) begin
            e_err[i] = 1'b1;
        end else if (mw) begin
            {e_pcf[i], e_iff[i], e_exf[i]} = 3'b111;
            n_wait[i] = m_wait[i] + 1;
        end else if (ex_br_taken) begin
            {e_ifl[i], e_idf[i]} = 2'b11;
        end else if (m_bub[i] > 0 || lu) begin
            {e_pcf[i], e_iff[i], e_idf[i]} = 3'b111;
            n_bub[i] = (m_bub[i] > 0) ? m_bub[i] - 1 : m_lb[i] - 1;
        end
        n_stall[i] = cnt_clr ? 0 : ((m_stall[i] + int'(e_pcf[i]) > m_max[i]) ? m_max[i] : m_stall[i] + int'(e_pcf[i]));
        n_flush[i] = cnt_clr ? 0 : ((m_flush[i] + int'(e_ifl[i]) > m_max[i]) ? m_max[i] : m_flush[i] + int'(e_ifl[i]));
        if (rst) begin
            n_bub[i] = 0; n_wait[i] = 0; n_stall[i] = 0; n_flush[i] = 0;
        end
    endtask

    // Called just after an edge with inputs already applied.
    task automatic step();
        #2;
        model_eval(0);
        model_eval(1);
        chk("A_pc_freeze", 32'(a_pcf), 32'(e_pcf[0]));
        chk("A_ifid_freeze", 32'(a_iff), 32'(e_iff[0]));
        chk("A_ifid_flush", 32'(a_ifl), 32'(e_ifl[0]));
        chk("A_idex_flush", 32'(a_idf), 32'(e_idf[0]));
        chk("A_exmem_freeze", 32'(a_exf), 32'(e_exf[0]));
        chk("A_mem_err", 32'(a_err), 32'(e_err[0]));
        chk("B_pc_freeze", 32'(b_pcf), 32'(e_pcf[1]));
        chk("B_ifid_freeze", 32'(b_iff), 32'(e_iff[1]));
        chk("B_ifid_flush", 32'(b_ifl), 32'(e_ifl[1]));
        chk("B_idex_flush", 32'(b_idf), 32'(e_idf[1]));
        chk("B_exmem_freeze", 32'(b_exf), 32'(e_exf[1]));
        chk("B_mem_err", 32'(b_err), 32'(e_err[1]));
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            m_bub[i] = n_bub[i]; m_wait[i] = n_wait[i];
            m_stall[i] = n_stall[i]; m_flush[i] = n_flush[i];
        end
        chk("A_stall_cnt", 32'(a_stall), 32'(m_stall[0]));
        chk("A_flush_cnt", 32'(a_flush), 32'(m_flush[0]));
        chk("B_stall_cnt", 32'(b_stall), 32'(m_stall[1]));
        chk("B_flush_cnt", 32'(b_flush), 32'(m_flush[1]));
    endtask

    task automatic cyc(input bit r, input bit req, input bit ack, input bit br, input bit ld,
                       input int rd, input int rs1, input int rs2, input bit u1, input bit u2,
                       input bit clr);
        rst = r; mem_req = req; mem_ack = ack; ex_br_taken = br; ex_is_load = ld;
        ex_rd = 3'(rd); id_rs1 = 3'(rs1); id_rs2 = 3'(rs2);
        id_use_rs1 = u1; id_use_rs2 = u2; cnt_clr = clr;
        step();
    endtask

    task automatic quiet(input int n);
        for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_bub[i] = 0; m_wait[i] = 0; m_stall[i] = 0; m_flush[i] = 0;
        end
        rst = 1'b1; mem_req = 0; mem_ack = 0; ex_br_taken = 0; ex_is_load = 0;
        ex_rd = '0; id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 0; id_use_rs2 = 0; cnt_clr = 0;
        @(posedge clk);
        #1;
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        quiet(1);
        // load-use on rs1, then on rs2, then with rd = 0
        cyc(0, 0, 0, 0, 1, 3, 3, 0, 1, 0, 0); quiet(4);
        cyc(0, 0, 0, 0, 1, 5, 1, 5, 0, 1, 0); quiet(4);
        cyc(0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0); quiet(3);
        // branch together with load-use
        cyc(0, 0, 0, 1, 1, 3, 3, 0, 1, 0, 0); quiet(3);
        // memory wait 4 cycles then ack, without and with a held branch
        for (int k = 0; k < 4; k++) cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0); quiet(2);
        for (int k = 0; k < 4; k++) cyc(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0); quiet(2);
        // timeout
        for (int k = 0; k < 11; k++) cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        quiet(2);
        // clear together with increment, then reset while stalled
        cyc(0, 0, 0, 0, 1, 2, 2, 0, 1, 0, 1); quiet(3);
        cyc(0, 0, 0, 0, 1, 4, 4, 0, 1, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); quiet(2);
        // saturation of the narrow stall counter
        for (int k = 0; k < 20; k++) cyc(0, 0, 0, 0, 1, 6, 6, 6, 1, 1, 0);
        quiet(3);
        // randomized traffic; alternating phases of rare and frequent acks
        for (int n = 0; n < 2000; n++) begin
            bit ack_rare;
            int rd;
            ack_rare = ((n / 200) % 2) == 1;
            rd = int'($urandom_range(0, 7));
            cyc(($urandom % 128) == 0,
                ($urandom % 3) == 0,
                ack_rare ? (($urandom % 16) == 0) : (($urandom % 2) == 0),
                ($urandom % 6) == 0,
                ($urandom % 2) == 0,
                rd,
                (($urandom % 2) == 0) ? rd : int'($urandom_range(0, 7)),
                (($urandom % 3) == 0) ? rd : int'($urandom_range(0, 7)),
                ($urandom % 4) != 0,
                ($urandom % 2) == 0,
                ($urandom % 50) == 0);
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
